// File: rtl/td_pkg.sv
// Shared types for the temporal-to-binary decoder: FSM states, the decoded
// result record and the epoch-length helper.
package td_pkg;

   // Result width; the decoder's BITS parameter defaults to this value.
   localparam int TD_BITS = 3;

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   typedef struct packed {
      logic [TD_BITS-1:0] value;
      logic               miss;
   } result_t;

   function automatic int period(input int bits);
      return (1 << bits) + 1;
   endfunction

endpackage

// File: rtl/td_decode_if.sv
// Temporal input pair plus the single-entry valid/ready result channel.
interface td_decode_if #(
   parameter int BITS = 3
);
   logic            tin;
   logic            tsig;
   logic            o_ready;
   logic            o_valid;
   logic [BITS-1:0] o_value;
   logic            o_miss;
   logic            o_overrun;

   modport master (
      output tin, tsig, o_ready,
      input  o_valid, o_value, o_miss, o_overrun
   );

   modport slave (
      input  tin, tsig, o_ready,
      output o_valid, o_value, o_miss, o_overrun
   );
endinterface

// File: rtl/td_edge_sync.sv
// Registers tin and tsig through matched stages and derives the epoch
// boundary pulse and the fired condition from the registered copies.
module td_edge_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic tin_i,
   input  logic tsig_i,
   output logic boundary_o,
   output logic fired_o
);

   logic tin_q;
   logic tsig_q;
   logic tinPrev_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tin_q     <= 1'b0;
         tsig_q    <= 1'b0;
         tinPrev_q <= 1'b0;
      end else begin
         tin_q     <= tin_i;
         tsig_q    <= tsig_i;
         tinPrev_q <= tin_q;
      end
   end

   // Both comparisons use the registered pair so a simultaneous toggle reads as k=0.
   assign boundary_o = tin_q ^ tinPrev_q;
   assign fired_o    = tsig_q ^ tin_q;

endmodule

// File: rtl/td_decode.sv
// Temporal-to-binary decoder: measures tsig arrival within each tin epoch
// and presents the result on a single-entry valid/ready holding register.
module td_decode
   import td_pkg::*;
#(
   parameter int BITS = TD_BITS
) (
   input  logic        clk,
   input  logic        rst_n,
   td_decode_if.slave  bus
);

   localparam int            CW        = BITS + 1;
   localparam logic [CW-1:0] CNT_MAX   = '1;
   localparam logic [CW-1:0] HIT_LIMIT = CW'(2 ** BITS);

   logic    boundary;
   logic    fired;

   state_t  state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] capK_q, capK_d;
   logic    hit_q, hit_d;
   logic    valid_q, valid_d;
   result_t held_q, held_d;
   logic    overrun_q, overrun_d;

   result_t epochRes;
   logic    loadNew;

   td_edge_sync u_sync (
      .clk        (clk),
      .rst_n      (rst_n),
      .tin_i      (bus.tin),
      .tsig_i     (bus.tsig),
      .boundary_o (boundary),
      .fired_o    (fired)
   );

   // The boundary cycle itself is k=0, so the register reloads with 1 rather than 0.
   always_comb begin
      cnt_d  = cnt_q;
      hit_d  = hit_q;
      capK_d = capK_q;
      if (boundary) begin
         cnt_d  = CW'(1);
         hit_d  = fired;
         capK_d = '0;
      end else begin
         if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
         end
         if (fired && !hit_q) begin
            hit_d  = 1'b1;
            capK_d = cnt_q;
         end
      end
   end

   always_comb begin
      epochRes.value = '1;
      epochRes.miss  = 1'b1;
      if (hit_q && (capK_q < HIT_LIMIT)) begin
         epochRes.value = capK_q[BITS-1:0];
         epochRes.miss  = 1'b0;
      end
   end

   // IDLE swallows the first boundary because the epoch before it was partial.
   always_comb begin
      state_d = state_q;
      loadNew = 1'b0;
      case (state_q)
         IDLE: begin
            if (boundary) begin
               state_d = RUN;
            end
         end
         RUN: begin
            loadNew = boundary;
         end
      endcase
   end

   always_comb begin
      valid_d   = valid_q;
      held_d    = held_q;
      overrun_d = 1'b0;
      if (loadNew) begin
         if (!valid_q || bus.o_ready) begin
            valid_d = 1'b1;
            held_d  = epochRes;
         end else begin
            overrun_d = 1'b1;
         end
      end else if (valid_q && bus.o_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         capK_q    <= '0;
         hit_q     <= 1'b0;
         valid_q   <= 1'b0;
         held_q    <= '0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         capK_q    <= capK_d;
         hit_q     <= hit_d;
         valid_q   <= valid_d;
         held_q    <= held_d;
         overrun_q <= overrun_d;
      end
   end

   assign bus.o_valid   = valid_q;
   assign bus.o_value   = held_q.value;
   assign bus.o_miss    = held_q.miss;
   assign bus.o_overrun = overrun_q;

endmodule
